// File: rtl/n64adv_vdemux_pkg.sv
// Shared types and field helpers for the N64 video demultiplexer.
// Group framing FSM encoding, vdata_o slice offsets and default widths.
package n64adv_vdemux_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2
  } vd_state_e;

  localparam int DEF_COLOR_W  = 7;
  localparam int DEF_CH       = 3;
  localparam int DEF_SYNC_W   = 4;
  localparam int DEF_TRUNC_W  = 5;
  localparam int DEF_ERRCNT_W = 8;

  localparam int NCSYNC_BIT = 0;

  // ch0 sits at the MSB side of the colour field
  function automatic int ch_lsb(
    input int k,
    input int ch,
    input int cw
  );
    return (ch - 1 - k) * cw;
  endfunction

  function automatic int sync_lsb(
    input int ch,
    input int cw
  );
    return ch * cw;
  endfunction

endpackage

// File: rtl/n64_vdemux_deblur.sv
// Deblur blanking: nblank is seeded from vmode on an nCSYNC rising edge
// between groups and toggles on every other group sync.
module n64_vdemux_deblur (
  input  logic VCLK,
  input  logic nRST,
  input  logic sync_stb_i,
  input  logic stg_ncsync_i,
  input  logic cur_ncsync_i,
  input  logic vmode_i,
  input  logic ndeblur_i,
  output logic nblank_o
);

  logic nblank_q;
  logic nblank_d;

  always_comb begin
    nblank_d = nblank_q;
    if (sync_stb_i) begin
      if (ndeblur_i)
        nblank_d = 1'b1;
      else if (!stg_ncsync_i && cur_ncsync_i)
        nblank_d = vmode_i;
      else
        nblank_d = ~nblank_q;
    end
  end

  always_ff @(posedge VCLK or negedge nRST) begin
    if (!nRST)
      nblank_q <= 1'b1;
    else
      nblank_q <= nblank_d;
  end

  assign nblank_o = nblank_q;

endmodule

// File: rtl/n64_vdemux_gen.sv
// Parametrised N64 VD demultiplexer: serial sync+colour groups to parallel.
// Define VDEMUX_GEN_PHASE_CHECK_EN to enable group-framing supervision.
module n64_vdemux_gen
  import n64adv_vdemux_pkg::*;
#(
  parameter int COLOR_W  = DEF_COLOR_W,
  parameter int CH       = DEF_CH,
  parameter int SYNC_W   = DEF_SYNC_W,
  parameter int TRUNC_W  = DEF_TRUNC_W,
  parameter int ERRCNT_W = DEF_ERRCNT_W
) (
  input  logic                          VCLK,
  input  logic                          nRST,
  input  logic                          nVDSYNC_i,
  input  logic [COLOR_W-1:0]            VD_i,
  input  logic                          vmode_i,
  input  logic                          ndeblur_i,
  input  logic                          n15bit_i,
  input  logic                          err_clr_i,
  output logic                          nVDSYNC_o,
  output logic [SYNC_W+CH*COLOR_W-1:0]  vdata_o,
  output logic                          vdata_valid_o,
  output logic                          phase_err_o,
  output logic [ERRCNT_W-1:0]           err_cnt_o
);

  localparam int CW   = CH * COLOR_W;
  localparam int VW   = SYNC_W + CW;
  localparam int PH_W = $clog2(CH + 1);
  localparam logic [PH_W-1:0] PH_FULL = PH_W'(CH);
  localparam logic [COLOR_W-1:0] TMASK =
    {COLOR_W{1'b1}} << (COLOR_W - TRUNC_W);

  vd_state_e           state_q, state_d;
  logic [PH_W-1:0]     phase_q, phase_d;
  logic [SYNC_W-1:0]   stg_sync_q, stg_sync_d;
  logic [CW-1:0]       stg_col_q, stg_col_d;
  logic [VW-1:0]       vdata_q, vdata_d;
  logic                valid_q, valid_d;
  logic                nvdsync_q, nvdsync_d;
  logic                perr_q, perr_d;
  logic [ERRCNT_W-1:0] ecnt_q, ecnt_d;

  logic               sync_cyc;
  logic               commit;
  logic               fill_ok;
  logic               err_evt;
  logic               nblank;
  logic [COLOR_W-1:0] cap_val;

  n64_vdemux_deblur u_deblur (
    .VCLK         (VCLK),
    .nRST         (nRST),
    .sync_stb_i   (sync_cyc),
    .stg_ncsync_i (stg_sync_q[NCSYNC_BIT]),
    .cur_ncsync_i (VD_i[NCSYNC_BIT]),
    .vmode_i      (vmode_i),
    .ndeblur_i    (ndeblur_i),
    .nblank_o     (nblank)
  );

  always_comb begin
    sync_cyc = ~nVDSYNC_i;
    commit   = sync_cyc && (state_q == ST_RUN);
    cap_val  = n15bit_i ? VD_i : (VD_i & TMASK);

`ifdef VDEMUX_GEN_PHASE_CHECK_EN
    fill_ok = (phase_q == PH_FULL);
    err_evt = (commit && (phase_q != PH_FULL))
            || (!sync_cyc && (phase_q == PH_FULL));
`else
    fill_ok = 1'b1;
    err_evt = 1'b0;
`endif

    phase_d = phase_q;
    if (sync_cyc)
      phase_d = '0;
    else if (phase_q != PH_FULL)
      phase_d = phase_q + PH_W'(1);

    stg_sync_d = sync_cyc ? VD_i[SYNC_W-1:0] : stg_sync_q;

    stg_col_d = stg_col_q;
    for (int k = 0; k < CH; k++) begin
      if (!sync_cyc && (phase_q == PH_W'(k)))
        stg_col_d[ch_lsb(k, CH, COLOR_W) +: COLOR_W] = cap_val;
    end

    // blanked groups keep the previous colours but still refresh sync
    vdata_d = vdata_q;
    if (commit) begin
      vdata_d[sync_lsb(CH, COLOR_W) +: SYNC_W] = stg_sync_q;
      if (nblank)
        vdata_d[CW-1:0] = stg_col_q;
    end

    valid_d   = commit;
    nvdsync_d = nVDSYNC_i;

    state_d = state_q;
    case (state_q)
      ST_IDLE: if (sync_cyc) state_d = ST_FILL;
      ST_FILL: if (sync_cyc && fill_ok) state_d = ST_RUN;
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_IDLE;
    endcase

    perr_d = perr_q;
    ecnt_d = ecnt_q;
    if (err_clr_i) begin
      perr_d = 1'b0;
      ecnt_d = '0;
    end else if (err_evt) begin
      perr_d = 1'b1;
      if (ecnt_q != {ERRCNT_W{1'b1}})
        ecnt_d = ecnt_q + ERRCNT_W'(1);
    end
  end

  always_ff @(posedge VCLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= ST_IDLE;
      phase_q    <= '0;
      stg_sync_q <= '0;
      stg_col_q  <= '0;
      vdata_q    <= '0;
      valid_q    <= 1'b0;
      nvdsync_q  <= 1'b1;
      perr_q     <= 1'b0;
      ecnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      stg_sync_q <= stg_sync_d;
      stg_col_q  <= stg_col_d;
      vdata_q    <= vdata_d;
      valid_q    <= valid_d;
      nvdsync_q  <= nvdsync_d;
      perr_q     <= perr_d;
      ecnt_q     <= ecnt_d;
    end
  end

  assign nVDSYNC_o     = nvdsync_q;
  assign vdata_o       = vdata_q;
  assign vdata_valid_o = valid_q;
  assign phase_err_o   = perr_q;
  assign err_cnt_o     = ecnt_q;

endmodule
